stroke_replay_buffer: RTL and testbench
=======================================

# stroke_replay_buffer

Captures one raw stroke of 5-bit (x,y) touch points and replays it twice: once into `curve_total_length`, then into `resample_point`. The second pass runs with the stroke's final total length held stable. The block sits directly upstream of the resampler, because resampling needs the complete curve length before the first point is processed.

## Interface

**Parameters**
- `DEPTH`, 64: maximum number of stored points per stroke.
- `AW`, 6: address width, equal to log2(`DEPTH`).

**Ports**
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_valid`, in, 1: input point strobe; accepted only when `o_ready`=1.
- `i_x`, in, 5: point x coordinate.
- `i_y`, in, 5: point y coordinate.
- `i_last`, in, 1: marks the final point of the stroke; qualified by `i_valid`.
- `o_ready`, out, 1: block can accept points.
- `i_total_length`, in, 20: running sum returned from `curve_total_length`.
- `o_pt_x`, out, 5: replayed point x.
- `o_pt_y`, out, 5: replayed point y.
- `o_len_valid`, out, 1: replayed point belongs to pass 1 (length pass).
- `o_res_valid`, out, 1: replayed point belongs to pass 2 (resample pass).
- `o_first`, out, 1: first point of the current pass.
- `o_total_length`, out, 20: latched stroke length, stable throughout pass 2.
- `o_count`, out, AW+1: number of stored points.
- `o_overflow`, out, 1: sticky flag, set when points were dropped in this stroke.
- `o_done`, out, 1: one-cycle pulse after pass 2 completes.

## Operation

**FSM states:** IDLE, CAPTURE, PASS1, SETTLE, PASS2, DONE.

**IDLE**
- `o_ready`=1.
- On the first accepted point:
  - write `mem[0]`, set `count`=1, clear `o_overflow`.
  - If `i_last` is also high, go to PASS1; otherwise go to CAPTURE.

**CAPTURE**
- `o_ready`=1.
- Each accepted point is written to `mem[count]` and `count` is incremented.
- When `count`==`DEPTH`:
  - further points are dropped and `o_overflow`←1.
  - `i_last` is still honoured, including on a dropped point.
- Accepted point with `i_last`=1 → PASS1.

**PASS1**
- `o_ready`=0; `i_valid` is ignored and memory is untouched.
- `rd_ptr` steps from 0 to `count`-1, one point per cycle.
- Outputs `mem[rd_ptr]` with `o_len_valid`=1.
- After the last point → SETTLE.

**SETTLE**
- Lasts exactly 1 cycle; `i_total_length` now holds the final sum.
- Latch `i_total_length` into `o_total_length` at the end of this cycle.
- → PASS2.

**PASS2**
- Same replay as PASS1, but with `o_res_valid`=1.
- `o_total_length` stays constant throughout.
- → DONE.

**DONE**
- `o_done`=1 for one cycle → IDLE.

**Width and data rules**
- No arithmetic is applied to coordinates.
- A 20-bit length is sufficient: the worst case is 64·2·31² = 123008.
- `o_count` and `o_overflow` hold until the next stroke starts.
- `o_total_length` holds until the next SETTLE.

## Timing

**Reset values:** all outputs are 0 except `o_ready`, which resets to 1. State resets to IDLE.

**Outputs:** all outputs are registered.

**Pass 1**
- `o_len_valid` is high for exactly `count` consecutive cycles.
- It starts the cycle after the edge that accepted `i_last`.

**SETTLE**
- SETTLE is the cycle immediately after the last `o_len_valid`; all valids are 0 during it.

**Pass 2**
- `o_res_valid` is high for `count` consecutive cycles, starting the cycle after SETTLE.
- `o_total_length` updates on the same edge that raises the first `o_res_valid`.

**Completion**
- `o_done` is asserted the cycle after the last `o_res_valid`.
- `o_ready` returns to 1 in the following cycle.

**Per-pass flags**
- `o_first` is coincident with the first valid of each pass.

**Latency:** total latency from `i_last` to `o_done` is 2·N+2 cycles.

**Reset mid-operation:** outputs clear immediately. Memory contents are don't-care because `count` is cleared.

**Single-point stroke (N=1):** each pass lasts 1 cycle, and `o_first` is high with it.

## Structure

**Package `gesture_pkg`**
- state enum `replay_state_t`.
- `COORD_W`=5.
- `LEN_W`=20.
- `NUM_RESAMPLE`=16, shared with the resampler.
- default `DEPTH`=64.

**Sub-module `stroke_point_ram`**
- `DEPTH`×10-bit register file.
- One synchronous write port and one registered read port.
- The FSM and counters stay in the top level.
- The read pointer is issued one cycle ahead so that read data aligns with the registered valids.

## Test plan

1. **Three-point stroke.**
   - Stimulus: (1,2), (4,6), (4,6) with `i_last` on the third; tie `i_total_length`=30 during SETTLE.
   - Required: `o_len_valid` for 3 cycles carrying (1,2), (4,6), (4,6); `o_first` on the first; then 1 SETTLE cycle.
   - Then: `o_res_valid` for 3 cycles with the same points and `o_total_length`=30; `o_done` 1 cycle later; `o_count`=3.
2. **Single point.**
   - Stimulus: (7,7) with `i_last`.
   - Required: 1-cycle `o_len_valid`, SETTLE, 1-cycle `o_res_valid`, then `o_done`.
   - Total of 4 cycles from acceptance to `o_done`.
3. **Overflow.**
   - Stimulus: 70 points with x = i mod 32, `i_last` on point 70.
   - Required: `o_count`=64, `o_overflow`=1, each pass 64 cycles replaying points 0..63 only.
4. **Input during replay.**
   - Stimulus: assert `i_valid` with (31,31) throughout PASS1.
   - Required: `o_ready`=0, input ignored, replayed data unchanged, `o_count` unchanged.
5. **Reset mid PASS2.**
   - Stimulus: assert `i_rst_n`=0 at the 2nd `o_res_valid`.
   - Required: all outputs 0 asynchronously and `o_ready`=1 after release.
   - Then: a new 2-point stroke replays correctly.
6. **Back-to-back strokes.**
   - Stimulus: a second stroke immediately after `o_done`, following an overflowed first stroke.
   - Required: `o_overflow` clears on the first accepted point; the new `o_count` is correct; the new `o_total_length` latches at the new SETTLE.

Source files
------------

// File: rtl/gesture_pkg.sv
`default_nettype none
// ============================================================================
// Package : gesture_pkg
// Brief   : Shared types and constants for the gesture front-end
//           (stroke capture/replay and resampling).
// Rev     : 1.0 - initial release
// ============================================================================
package gesture_pkg;

  localparam int COORD_W       = 5;
  localparam int LEN_W         = 20;
  localparam int NUM_RESAMPLE  = 16;
  localparam int DEFAULT_DEPTH = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_PASS1   = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_PASS2   = 3'd4,
    ST_DONE    = 3'd5
  } replay_state_t;

endpackage
`default_nettype wire

// File: rtl/stroke_point_ram.sv
`default_nettype none
// ============================================================================
// Module : stroke_point_ram
// Brief  : DEPTH x DW register file, one synchronous write port and one
//          registered read port. A same-cycle write to the address being
//          read is forwarded so a single-point stroke replays its own point.
// Rev    : 1.0 - initial release
// ============================================================================
module stroke_point_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Point storage; contents need no reset because the point count gates use.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read with write-through forwarding on address collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data <= '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/stroke_replay_buffer.sv
`default_nettype none
// ============================================================================
// Module : stroke_replay_buffer
// Brief  : Captures one stroke of (x,y) points, replays it once for the
//          length accumulator, waits one settle cycle, latches the total
//          length and replays it again for the resampler.
// Rev    : 1.0 - initial release
// ============================================================================
module stroke_replay_buffer
  import gesture_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_last,
  output logic               o_ready,
  input  logic [LEN_W-1:0]   i_total_length,
  output logic [COORD_W-1:0] o_pt_x,
  output logic [COORD_W-1:0] o_pt_y,
  output logic               o_len_valid,
  output logic               o_res_valid,
  output logic               o_first,
  output logic [LEN_W-1:0]   o_total_length,
  output logic [AW:0]        o_count,
  output logic               o_overflow,
  output logic               o_done
);

  replay_state_t state, state_nxt;
  logic [AW-1:0] rd_ptr, rd_ptr_nxt;
  logic [AW:0]   count;
  logic          overflow;
  logic          accept;
  logic          full;
  logic          last_rd;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [2*COORD_W-1:0] rd_data;

  assign accept  = i_valid && o_ready;
  assign full    = (count == (AW+1)'(DEPTH));
  assign last_rd = ({1'b0, rd_ptr} == (count - 1'b1));

  // Next-state, next read address (issued a cycle ahead) and write control.
  always_comb begin
    state_nxt  = state;
    rd_ptr_nxt = rd_ptr;
    wr_en      = 1'b0;
    wr_addr    = count[AW-1:0];
    case (state)
      ST_IDLE: begin
        if (accept) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          rd_ptr_nxt = '0;
          state_nxt  = i_last ? ST_PASS1 : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (accept) begin
          wr_en = !full;
          if (i_last) begin
            rd_ptr_nxt = '0;
            state_nxt  = ST_PASS1;
          end
        end
      end
      ST_PASS1: begin
        if (last_rd) state_nxt = ST_SETTLE;
        else         rd_ptr_nxt = rd_ptr + AW'(1);
      end
      ST_SETTLE: begin
        rd_ptr_nxt = '0;
        state_nxt  = ST_PASS2;
      end
      ST_PASS2: begin
        if (last_rd) state_nxt = ST_DONE;
        else         rd_ptr_nxt = rd_ptr + AW'(1);
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State and read pointer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      rd_ptr <= '0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Point count and sticky overflow, both held until the next stroke starts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (accept && (state == ST_IDLE)) begin
      count    <= (AW+1)'(1);
      overflow <= 1'b0;
    end else if (accept && (state == ST_CAPTURE)) begin
      if (full) overflow <= 1'b1;
      else      count    <= count + 1'b1;
    end
  end

  // Registered handshake/pass flags decoded from the upcoming state, plus
  // the length latch that closes the settle cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ready        <= 1'b1;
      o_len_valid    <= 1'b0;
      o_res_valid    <= 1'b0;
      o_first        <= 1'b0;
      o_done         <= 1'b0;
      o_total_length <= '0;
    end else begin
      o_ready     <= (state_nxt == ST_IDLE) || (state_nxt == ST_CAPTURE);
      o_len_valid <= (state_nxt == ST_PASS1);
      o_res_valid <= (state_nxt == ST_PASS2);
      o_first     <= ((state_nxt == ST_PASS1) && (state != ST_PASS1)) ||
                     ((state_nxt == ST_PASS2) && (state != ST_PASS2));
      o_done      <= (state_nxt == ST_DONE);
      if (state == ST_SETTLE) o_total_length <= i_total_length;
    end
  end

  stroke_point_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (2*COORD_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({i_x, i_y}),
    .rd_addr (rd_ptr_nxt),
    .rd_data (rd_data)
  );

  assign o_pt_x     = rd_data[2*COORD_W-1:COORD_W];
  assign o_pt_y     = rd_data[COORD_W-1:0];
  assign o_count    = count;
  assign o_overflow = overflow;

endmodule
`default_nettype wire

// File: tb/tb_stroke_replay_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_stroke_replay_buffer
// Brief  : Self-checking bench for stroke_replay_buffer. Each stroke's
//          expected replay is derived from a queue of the points sent.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_stroke_replay_buffer;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [4:0]  i_x = '0;
  logic [4:0]  i_y = '0;
  logic        i_last = 1'b0;
  logic [19:0] i_total_length = '0;
  logic        o_ready;
  logic [4:0]  o_pt_x;
  logic [4:0]  o_pt_y;
  logic        o_len_valid;
  logic        o_res_valid;
  logic        o_first;
  logic [19:0] o_total_length;
  logic [AW:0] o_count;
  logic        o_overflow;
  logic        o_done;

  always #5 clk = ~clk;

  stroke_replay_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid        (i_valid),
    .i_x            (i_x),
    .i_y            (i_y),
    .i_last         (i_last),
    .o_ready        (o_ready),
    .i_total_length (i_total_length),
    .o_pt_x         (o_pt_x),
    .o_pt_y         (o_pt_y),
    .o_len_valid    (o_len_valid),
    .o_res_valid    (o_res_valid),
    .o_first        (o_first),
    .o_total_length (o_total_length),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .o_done         (o_done)
  );

  int n_vec  = 0;
  int n_miss = 0;
  // Model state carried between strokes.
  int prev_count = 0;
  int prev_ovf   = 0;
  int prev_len   = 0;
  int px[$];
  int py[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_len_valid", int'(o_len_valid), 0);
    chk("rst_res_valid", int'(o_res_valid), 0);
    chk("rst_first", int'(o_first), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_pt_x", int'(o_pt_x), 0);
    chk("rst_pt_y", int'(o_pt_y), 0);
    chk("rst_total", int'(o_total_length), 0);
    chk("rst_count", int'(o_count), 0);
    chk("rst_ovf", int'(o_overflow), 0);
  endtask

  // Sends the n points in px/py, then follows the replay cycle by cycle.
  // junk: drive (31,31) with i_valid during pass 1. abort_at: cycle after
  // the last-point edge at which reset is pulsed (0 = never).
  task automatic run_stroke(input int n, input bit junk, input int abort_at, input int len_val);
    int stored;
    int idx;
    stored = (n > DEPTH) ? DEPTH : n;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("cap_ready", int'(o_ready), 1);
      if (k == 0) begin
        chk("hold_done", int'(o_done), 0);
        chk("hold_count", int'(o_count), prev_count);
        chk("hold_ovf", int'(o_overflow), prev_ovf);
      end else begin
        chk("cap_count", int'(o_count), (k > DEPTH) ? DEPTH : k);
        chk("cap_ovf", int'(o_overflow), (k > DEPTH) ? 1 : 0);
      end
      i_valid = 1'b1;
      i_x     = 5'(px[k]);
      i_y     = 5'(py[k]);
      i_last  = (k == n - 1);
    end
    for (int c = 1; c <= 2 * stored + 2; c++) begin
      @(negedge clk);
      if (junk && c <= stored) begin
        i_valid = 1'b1; i_x = 5'd31; i_y = 5'd31; i_last = 1'($urandom_range(0, 1));
      end else begin
        i_valid = 1'b0; i_last = 1'b0;
      end
      i_total_length = (c == stored + 1) ? 20'(len_val) : 20'($urandom_range(0, 20'hFFFFF));
      chk("count_hold", int'(o_count), stored);
      chk("ready_low", int'(o_ready), 0);
      if (c <= stored) begin
        idx = c - 1;
        chk("p1_len_valid", int'(o_len_valid), 1);
        chk("p1_res_valid", int'(o_res_valid), 0);
        chk("p1_first", int'(o_first), (c == 1) ? 1 : 0);
        chk("p1_x", int'(o_pt_x), px[idx]);
        chk("p1_y", int'(o_pt_y), py[idx]);
        chk("p1_total_old", int'(o_total_length), prev_len);
      end else if (c == stored + 1) begin
        chk("settle_len_valid", int'(o_len_valid), 0);
        chk("settle_res_valid", int'(o_res_valid), 0);
        chk("settle_done", int'(o_done), 0);
        chk("settle_total_old", int'(o_total_length), prev_len);
      end else if (c <= 2 * stored + 1) begin
        idx = c - stored - 2;
        chk("p2_res_valid", int'(o_res_valid), 1);
        chk("p2_len_valid", int'(o_len_valid), 0);
        chk("p2_first", int'(o_first), (idx == 0) ? 1 : 0);
        chk("p2_x", int'(o_pt_x), px[idx]);
        chk("p2_y", int'(o_pt_y), py[idx]);
        chk("p2_total", int'(o_total_length), len_val);
      end else begin
        chk("done_pulse", int'(o_done), 1);
        chk("done_res_valid", int'(o_res_valid), 0);
        chk("done_total", int'(o_total_length), len_val);
        chk("done_ovf", int'(o_overflow), (n > DEPTH) ? 1 : 0);
      end
      if (c == abort_at) begin
        rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        check_reset_outputs();
        prev_count = 0; prev_ovf = 0; prev_len = 0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    prev_count = stored;
    prev_ovf   = (n > DEPTH) ? 1 : 0;
    prev_len   = len_val;
  endtask

  task automatic make_random(input int n);
    px.delete(); py.delete();
    for (int i = 0; i < n; i++) begin
      px.push_back(int'($urandom_range(0, 31)));
      py.push_back(int'($urandom_range(0, 31)));
    end
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // Three-point stroke with a known length.
    px = '{1, 4, 4}; py = '{2, 6, 6};
    run_stroke(3, 1'b0, 0, 30);

    // Single point.
    px = '{7}; py = '{7};
    run_stroke(1, 1'b0, 0, int'($urandom_range(0, 123008)));

    // Input held active throughout pass 1.
    make_random(5);
    run_stroke(5, 1'b1, 0, int'($urandom_range(0, 123008)));

    // Overflow, then a second stroke immediately after o_done.
    px.delete(); py.delete();
    for (int i = 0; i < 70; i++) begin
      px.push_back(i % 32);
      py.push_back(int'($urandom_range(0, 31)));
    end
    run_stroke(70, 1'b0, 0, int'($urandom_range(0, 123008)));
    make_random(4);
    run_stroke(4, 1'b0, 0, int'($urandom_range(0, 123008)));

    // Reset at the second pass-2 point, then a fresh 2-point stroke.
    make_random(3);
    run_stroke(3, 1'b0, 3 + 3, int'($urandom_range(0, 123008)));
    make_random(2);
    run_stroke(2, 1'b0, 0, int'($urandom_range(0, 123008)));

    // Randomized strokes, occasionally overflowing.
    for (int s = 0; s < 10; s++) begin
      n = (s % 4 == 3) ? int'($urandom_range(60, 72)) : int'($urandom_range(1, 20));
      make_random(n);
      run_stroke(n, 1'($urandom_range(0, 1)), 0, int'($urandom_range(0, 123008)));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
